// File: rtl/ram8_clr_if.sv
// Bus interface for ram8_clr: write/read/clear signals grouped for master and slave sides.
interface ram8_clr_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] in_i;
  logic             load_i;
  logic [2:0]       address_i;
  logic             clr_i;
  logic [WIDTH-1:0] out_o;
  logic             busy_o;

  modport master (
    output in_i, load_i, address_i, clr_i,
    input  out_o, busy_o
  );

  modport slave (
    input  in_i, load_i, address_i, clr_i,
    output out_o, busy_o
  );
endinterface

// File: rtl/ram8_clr.sv
// Eight-word register file with an eight-cycle clear sequencer.
// Optional macro RAM8_CLR_WRITE_FWD_EN enables write-through forwarding on out_o.
module ram8_clr #(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  ram8_clr_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [8];
  logic [WIDTH-1:0] mem_d [8];
  logic [7:0]       load_sel;

  // 8-way demux of the write strobe
  always_comb begin
    load_sel = 8'(bus.load_i) << bus.address_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    unique case (state_q)
      StIdle: begin
        for (int i = 0; i < 8; i++) begin
          if (load_sel[i]) mem_d[i] = bus.in_i;
        end
        if (bus.clr_i) begin
          state_d = StClear;
          cnt_d   = 3'd0;
        end
      end
      StClear: begin
        // Loads and further clear requests are ignored until the sweep ends.
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.busy_o = (state_q == StClear);

  always_comb begin
`ifdef RAM8_CLR_WRITE_FWD_EN
    if (state_q == StIdle && bus.load_i) begin
      bus.out_o = bus.in_i;
    end else begin
      bus.out_o = mem_q[bus.address_i];
    end
`else
    bus.out_o = mem_q[bus.address_i];
`endif
  end

endmodule
